// File: rtl/master_control_if.sv
// master_control_if: off-chip transfer link between initiator and responder.
//   request  : initiator -> responder, transfer requested
//   valid    : initiator -> responder, data_out is valid
//   data_out : initiator -> responder, 3-bit payload
//   ack      : responder -> initiator, acknowledge (asynchronous to clk)
// Modports: master (initiator side), slave (responder side).
interface master_control_if;
  logic       request;
  logic       valid;
  logic [2:0] data_out;
  logic       ack;

  modport master (output request, output valid, output data_out, input ack);
  modport slave  (input request, input valid, input data_out, output ack);
endinterface

// File: rtl/master_control.sv
// master_control: initiator side of the chip-to-chip 3-bit transfer link.
// A one-cycle send pulse captures data_sw and raises request. Once the
// synchronized ack is seen, a notice period of DELAY_CYCLES is held, then
// data is presented with valid. The transfer closes when ack falls.
//
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   send     : one-cycle pulse, start a transfer (ignored while busy)
//   data_sw  : value to transmit, captured on an accepted send
//   link     : master_control_if.master (request, valid, data_out, ack)
//   notice   : LED, high while waiting for ack and during the hold period
//   busy     : high in every state except IDLE
//   error    : ack timeout flag
//
// Build option: define MASTER_TIMEOUT_EN to abort WAIT_ACK/SEND after
// TIMEOUT_CYCLES without the awaited ack edge. Without it, error stays 0.
module master_control #(
  parameter int unsigned DELAY_CYCLES   = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
  parameter int unsigned CNT_W          = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   send,
  input  logic [2:0]             data_sw,
  master_control_if.master       link,
  output logic                   notice,
  output logic                   busy,
  output logic                   error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    HOLD     = 2'd2,
    SEND     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state, state_d;
  logic             ack_meta, ack_s;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             request_d, valid_d, notice_d, busy_d, error_d;
  logic [2:0]       data_d;

  // Two-flop synchronizer for the off-chip ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= link.ack;
      ack_s    <= ack_meta;
    end
  end

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      link.request  <= 1'b0;
      link.valid    <= 1'b0;
      link.data_out <= '0;
      notice        <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      link.request  <= request_d;
      link.valid    <= valid_d;
      link.data_out <= data_d;
      notice        <= notice_d;
      busy          <= busy_d;
      error         <= error_d;
    end
  end

`ifndef MASTER_TIMEOUT_EN
  // TIMEOUT_CYCLES has no effect in this build.
  logic [CNT_W-1:0] unused_timeout;
  assign unused_timeout = TIMEOUT_LAST;
`endif

  // Next-state and next-output logic. Output values are those of the
  // state being entered, so registered outputs line up with the state.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    request_d = link.request;
    valid_d   = link.valid;
    data_d    = link.data_out;
    notice_d  = notice;
    busy_d    = busy;
    error_d   = error;

    case (state)
      IDLE: begin
        request_d = 1'b0;
        valid_d   = 1'b0;
        notice_d  = 1'b0;
        busy_d    = 1'b0;
        // ack_s is deliberately not looked at here.
        if (send) begin
          data_d    = data_sw;
          request_d = 1'b1;
          notice_d  = 1'b1;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          cnt_d     = '0;
          state_d   = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        request_d = 1'b1;
        valid_d   = 1'b0;
        notice_d  = 1'b1;
        busy_d    = 1'b1;
        if (ack_s) begin
          request_d = 1'b0;
          cnt_d     = '0;
          state_d   = HOLD;
        end
`ifdef MASTER_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          request_d = 1'b0;
          notice_d  = 1'b0;
          busy_d    = 1'b0;
          error_d   = 1'b1;
          state_d   = IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_ONE;
        end
`endif
      end

      HOLD: begin
        request_d = 1'b0;
        valid_d   = 1'b0;
        notice_d  = 1'b1;
        busy_d    = 1'b1;
        if (cnt == DELAY_LAST) begin
          valid_d  = 1'b1;
          notice_d = 1'b0;
          cnt_d    = '0;
          state_d  = SEND;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      SEND: begin
        request_d = 1'b0;
        valid_d   = 1'b1;
        notice_d  = 1'b0;
        busy_d    = 1'b1;
        if (!ack_s) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef MASTER_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          error_d = 1'b1;
          state_d = IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_ONE;
        end
`endif
      end

      default: begin
        request_d = 1'b0;
        valid_d   = 1'b0;
        notice_d  = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_master_control.sv
// tb_master_control: directed self-checking bench for master_control with
// DELAY_CYCLES=4 and TIMEOUT_CYCLES=10. The timeout scenario runs only when
// MASTER_TIMEOUT_EN is defined.
module tb_master_control;

  logic       clk;
  logic       rst_n;
  logic       send;
  logic [2:0] data_sw;
  logic       notice;
  logic       busy;
  logic       error;

  int checks = 0;
  int errors = 0;

  master_control_if link ();

  master_control #(
    .DELAY_CYCLES  (4),
    .TIMEOUT_CYCLES(10),
    .CNT_W         (28)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .send   (send),
    .data_sw(data_sw),
    .link   (link),
    .notice (notice),
    .busy   (busy),
    .error  (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // request and valid must never be high together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!(link.request === 1'b1 && link.valid === 1'b1))
      else begin
        errors++;
        $error("FAIL overlap: observed request=%b valid=%b expected not both 1",
               link.request, link.valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_request"}, 32'(link.request), 0);
    chk({tag, "_valid"},   32'(link.valid),   0);
    chk({tag, "_notice"},  32'(notice),       0);
    chk({tag, "_busy"},    32'(busy),         0);
  endtask

  // Full transfer with a modelled responder. Edge numbering: P1 = edge that
  // accepts send. ack raised after P5, seen as ack_s after P7, HOLD entered
  // at P8, valid at P12, ack dropped after P14, valid falls at P17.
  task automatic do_transfer(input logic [2:0] d, input bit poke_busy);
    data_sw = d;
    send    = 1'b1;
    tick();                                   // P1
    send    = 1'b0;
    data_sw = ~d;
    chk("wa_request", 32'(link.request), 1);
    chk("wa_notice",  32'(notice),       1);
    chk("wa_busy",    32'(busy),         1);
    chk("wa_valid",   32'(link.valid),   0);
    chk("wa_error",   32'(error),        0);
    chk("wa_data",    32'(link.data_out), 32'(d));
    for (int i = 0; i < 4; i++) begin         // P2..P5
      tick();
      chk("wa_request_hold", 32'(link.request), 1);
      chk("wa_valid_low",    32'(link.valid),   0);
    end
    link.ack = 1'b1;
    tick();                                   // P6
    chk("sync1_request", 32'(link.request), 1);
    tick();                                   // P7
    chk("sync2_request", 32'(link.request), 1);
    tick();                                   // P8: HOLD entry
    chk("hold_request", 32'(link.request), 0);
    chk("hold_notice",  32'(notice),       1);
    chk("hold_valid",   32'(link.valid),   0);
    chk("hold_busy",    32'(busy),         1);
    for (int i = 0; i < 3; i++) begin         // P9..P11
      if (poke_busy && i == 0) begin
        data_sw = 3'b010;
        send    = 1'b1;
      end
      tick();
      send = 1'b0;
      chk("hold_valid_low", 32'(link.valid),    0);
      chk("hold_notice_hi", 32'(notice),        1);
      chk("hold_data",      32'(link.data_out), 32'(d));
    end
    tick();                                   // P12
    chk("send_valid",   32'(link.valid),    1);
    chk("send_notice",  32'(notice),        0);
    chk("send_request", 32'(link.request),  0);
    chk("send_data",    32'(link.data_out), 32'(d));
    tick();                                   // P13
    chk("send_valid_p13", 32'(link.valid), 1);
    tick();                                   // P14
    chk("send_valid_p14", 32'(link.valid), 1);
    link.ack = 1'b0;
    tick();                                   // P15
    chk("send_valid_p15", 32'(link.valid), 1);
    tick();                                   // P16
    chk("send_valid_p16", 32'(link.valid), 1);
    tick();                                   // P17
    chk_idle("done");
    chk("done_data", 32'(link.data_out), 32'(d));
  endtask

  initial begin
    rst_n    = 1'b0;
    send     = 1'b0;
    data_sw  = 3'b000;
    link.ack = 1'b0;

    // Reset then idle.
    repeat (3) tick();
    chk_idle("rst");
    chk("rst_data",  32'(link.data_out), 0);
    chk("rst_error", 32'(error),         0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle("idle");
      chk("idle_data",  32'(link.data_out), 0);
      chk("idle_error", 32'(error),         0);
    end

    // Normal transfer with a second send injected during HOLD.
    do_transfer(3'b101, 1'b1);
    tick();
    chk_idle("once");
    chk("once_data", 32'(link.data_out), 32'(3'b101));

    // Async reset while valid is high.
    data_sw = 3'b011;
    send    = 1'b1;
    tick();
    send = 1'b0;
    repeat (4) tick();
    link.ack = 1'b1;
    repeat (3) tick();
    repeat (4) tick();
    chk("pre_rst_valid", 32'(link.valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_data", 32'(link.data_out), 0);
    link.ack = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    do_transfer(3'b100, 1'b0);

    // Back-to-back, send one cycle after busy falls.
    tick();
    do_transfer(3'b001, 1'b0);
    tick();
    do_transfer(3'b110, 1'b0);

`ifdef MASTER_TIMEOUT_EN
    // ack never rises: abort after 10 cycles of WAIT_ACK.
    tick();
    data_sw = 3'b111;
    send    = 1'b1;
    tick();
    send = 1'b0;
    chk("to_request_start", 32'(link.request), 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("to_request_wait", 32'(link.request), 1);
      chk("to_error_low",    32'(error),        0);
    end
    tick();
    chk_idle("to_abort");
    chk("to_error", 32'(error), 1);
    repeat (3) tick();
    chk("to_error_sticky", 32'(error), 1);
    do_transfer(3'b011, 1'b0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/master_control.md
Name: master_control

Overview:
Initiator side of the chip-to-chip 3-bit transfer link. On a one-cycle send pulse it captures the switch value and raises request. It waits for the responder's ack, holds a notice period, then presents data with valid. It closes the transaction when ack falls. It sits between the board's debounced/one-pulsed send button and the off-chip request/valid/data pins, and drives a notice LED.

Parameters:
DELAY_CYCLES, 100_000_000, notice hold after ack is seen, in clk cycles (1 s at 100 MHz); minimum 1
TIMEOUT_CYCLES, 200_000_000, ack wait limit (used only with MASTER_TIMEOUT_EN)
CNT_W, 28, width of the shared internal counter; must hold max(DELAY_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
send  in  1  one-cycle pulse: start a transfer
data_sw  in  3  value to transmit, sampled on accepted send
ack  in  1  ack from responder, asynchronous to clk
request  out  1  request to responder
valid  out  1  data_out is valid; responder samples on it
data_out  out  3  data to responder
notice  out  1  LED: transfer in progress / ack period
busy  out  1  high in every state except IDLE
error  out  1  ack timeout flag (0 when feature is off)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; request=0, valid=0, data_out=0, notice=0, busy=0, error=0; counter=0; sync flops=0. All outputs are registered.
- ack passes through a 2-flop synchronizer to give ack_s; all decisions use ack_s (2-3 cycle latency from the pin).
- IDLE: outputs low except data_out, which holds its last value. On send=1: data_out<=data_sw, request<=1, busy<=1, error<=0, go to WAIT_ACK.
- WAIT_ACK: request=1, notice=1. On ack_s=1: request<=0, counter<=0, go to HOLD.
- HOLD: notice=1, request=0, valid=0. Counter increments each cycle. When counter==DELAY_CYCLES-1, go to SEND: valid<=1, so valid rises DELAY_CYCLES cycles after HOLD entry.
- SEND: valid=1, data_out stable, notice=0. On ack_s=0: valid<=0, go to IDLE, busy<=0.
- data_out changes only on an accepted send. It is stable from request rise through valid fall.
- request and valid are never both 1.
- send while busy=1 is ignored and data_sw is not captured.
- send and ack_s arriving in the same IDLE cycle: send is accepted; ack_s is ignored until WAIT_ACK.
- Reset mid-transfer: request and valid drop immediately (async). The responder recovers by returning to its wait-for-request state.
- Counter saturates; it never wraps in HOLD.
- Unused state encoding: go to IDLE with IDLE outputs.

Optional Feature:
MASTER_TIMEOUT_EN
- Defined: the counter also runs in WAIT_ACK and in SEND, cleared on entry to each. If it reaches TIMEOUT_CYCLES-1 before the awaited ack edge:
  - request<=0, valid<=0, error<=1, go to IDLE.
  - error stays high until the next accepted send or reset.
- Undefined: no timeout; WAIT_ACK and SEND wait indefinitely; error is constant 0 and TIMEOUT_CYCLES is unused.

Test Plan:
- Reset then idle, DELAY_CYCLES=4: rst_n low for 3 cycles, release, no send for 20 cycles -> request=valid=notice=busy=error=0, data_out=0.
- Normal transfer, DELAY_CYCLES=4: data_sw=3'b101, send pulse; model responder raises ack 5 cycles after request and drops ack 2 cycles after valid.
  - Required: request high until ack_s=1.
  - valid rises exactly 4 cycles after HOLD entry with data_out=3'b101.
  - valid falls on the cycle after ack_s=0.
  - busy returns to 0; request and valid never overlap.
- Send while busy: second send with data_sw=3'b010 during HOLD -> ignored; data_out remains 3'b101 and the transaction completes once.
- Async reset mid-SEND: assert rst_n=0 between clock edges while valid=1 -> valid and request go 0 before the next clk edge; the next send completes normally.
- Back-to-back transfers 3'b001 then 3'b110, with send issued 1 cycle after busy falls -> both values delivered in order, each with its own request/ack/valid cycle.
- MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, ack never rises -> request drops and error=1 at cycle 10 of WAIT_ACK, state IDLE; next send clears error to 0.
